imem_fetch_unit: RTL
====================

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the instruction word width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, default 8, SHALL set the byte-address width.
REQ-003 Parameter DEPTH, default 128, SHALL set the number of instruction words stored.
REQ-004 Parameter RD_LAT, default 1, legal values 1 or 2, SHALL set the read latency in cycles.
REQ-005 Ports SHALL be, one per line, as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request can be accepted this cycle.
- req_addr  in  ADDR_W  fetch byte address.
- rsp_valid  out  1  fetch response valid (no backpressure).
- rsp_data  out  DATA_W  fetched instruction word.
- rsp_fault  out  1  response is for a misaligned or out-of-range address.
- prog_en  in  1  request program (load) mode.
- prog_wr  in  1  write strobe, honoured only in PROG.
- prog_addr  in  ADDR_W  program byte address.
- prog_data  in  DATA_W  program write data.
- prog_active  out  1  block is in PROG state.

Function
REQ-006 Word index SHALL be addr / (DATA_W/8); an address is aligned when addr mod (DATA_W/8) == 0.
REQ-007 State machine SHALL have states IDLE, DRAIN and PROG.
REQ-008 IDLE SHALL assert req_ready = !prog_en.
REQ-009 A request SHALL be accepted on any cycle where req_valid && req_ready.
REQ-010 Back-to-back accepts SHALL be supported, one per cycle.
REQ-011 An accepted request SHALL produce exactly one response, with rsp_valid high exactly RD_LAT cycles after the accept edge.
REQ-012 Responses SHALL be returned in request order.
REQ-013 An aligned, in-range request (index < DEPTH) SHALL return rsp_data = mem[index] and rsp_fault = 0.
REQ-014 A misaligned or out-of-range request SHALL return rsp_data = 0 and rsp_fault = 1, and SHALL NOT access memory.
REQ-015 When rsp_valid = 0, rsp_data and rsp_fault SHALL be 0.
REQ-016 IDLE with prog_en = 1 SHALL go to DRAIN if any response is in flight, otherwise directly to PROG.
REQ-017 DRAIN SHALL hold req_ready = 0 and go to PROG on the cycle after the last in-flight response is presented.
REQ-018 PROG SHALL hold req_ready = 0 and prog_active = 1.
REQ-019 In PROG, prog_wr = 1 with an aligned, in-range prog_addr SHALL write prog_data to mem[index] at that edge.
REQ-020 In PROG, prog_wr to a misaligned or out-of-range prog_addr SHALL be ignored silently.
REQ-021 PROG with prog_en = 0 SHALL go to IDLE; req_ready SHALL rise the following cycle.
REQ-022 prog_wr outside PROG SHALL be ignored.
REQ-023 A word written in PROG SHALL be visible to the first fetch accepted after the return to IDLE.
REQ-024 The in-flight counter SHALL be sized to hold RD_LAT and SHALL neither overflow nor underflow under any input sequence.

Reset
REQ-025 Reset SHALL force state IDLE, clear the pipeline and the in-flight count, and drive rsp_valid, rsp_data, rsp_fault and prog_active to 0.
REQ-026 While reset = 1, req_ready SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL drop in-flight responses, producing no rsp_valid on the following cycles.
REQ-028 Reset SHALL abort PROG without a write on the reset edge.
REQ-029 Memory contents SHALL be retained across reset and are undefined only at power-up.

Verification
REQ-030 Program-then-fetch: prog_en = 1, write 0x1234 @0x00 and 0xBEEF @0x02, prog_en = 0; fetch 0x00, 0x02 back-to-back -> rsp 0x1234 then 0xBEEF, fault = 0, RD_LAT cycles after each accept.
REQ-031 Fault cases: fetch 0x03 -> rsp_fault = 1, rsp_data = 0; with DEPTH = 64, fetch 0x80 -> rsp_fault = 1.
REQ-032 Drain: RD_LAT = 2, accept 0x00, raise prog_en next cycle -> state DRAIN, req_ready = 0, response still delivered, then prog_active = 1.
REQ-033 Reset mid-fetch: accept 0x02, assert reset the next cycle -> no rsp_valid; after reset release, fetch 0x02 -> 0xBEEF (memory retained).
REQ-034 Guarded writes: prog_wr to 0x01 in PROG and to 0x00 in IDLE -> subsequent fetches of 0x00 return the unchanged value.
REQ-035 Parameter sweep: run REQ-030 to REQ-033 at DATA_W = 32, ADDR_W = 10, RD_LAT = 1 and 2 -> latency and alignment (4-byte) rules hold.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
//
// Instruction memory with a fetch port and a program (load) port.
//
// A fetch request is accepted on any cycle where req_valid && req_ready. The
// response appears on rsp_valid exactly RD_LAT cycles after the accept edge,
// in request order, with no backpressure. Misaligned or out-of-range addresses
// return rsp_fault = 1 and rsp_data = 0 without touching memory.
//
// Program mode (PROG) is entered with prog_en. If responses are still in
// flight, the unit first passes through DRAIN until the last one has been
// presented. Writes through the program port land only in PROG.
//
// Parameters
//   DATA_W : instruction word width in bits (multiple of 8)
//   ADDR_W : byte-address width
//   DEPTH  : number of instruction words stored
//   RD_LAT : fetch read latency in cycles (1 or 2)
//
// Ports
//   clk         : sole clock, rising edge
//   reset       : synchronous, active-high reset
//   req_valid   : fetch request present
//   req_ready   : fetch request can be accepted this cycle
//   req_addr    : fetch byte address
//   rsp_valid   : fetch response valid
//   rsp_data    : fetched instruction word (0 when invalid or faulting)
//   rsp_fault   : response is for a misaligned or out-of-range address
//   prog_en     : request program mode
//   prog_wr     : program write strobe (honoured only in PROG)
//   prog_addr   : program byte address
//   prog_data   : program write data
//   prog_active : unit is in PROG state
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fault,
    input  logic              prog_en,
    input  logic              prog_wr,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_active
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int unsigned BYTES_U = DATA_W / 8;
    localparam int unsigned DEPTH_U = DEPTH;
    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W   = $clog2(RD_LAT + 1);
    localparam int          LAST    = RD_LAT - 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PROG  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Address helpers
    // -------------------------------------------------------------------------
    // An address is usable when it is word aligned and its word index is
    // inside the array.
    function automatic logic addr_usable(input logic [ADDR_W-1:0] addr);
        int unsigned a;
        a = 32'(addr);
        return ((a % BYTES_U) == 32'd0) && ((a / BYTES_U) < DEPTH_U);
    endfunction

    // Word index truncated to the array index width; only meaningful when
    // addr_usable() is true.
    function automatic logic [MEM_AW-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        int unsigned a;
        a = 32'(addr) / BYTES_U;
        return MEM_AW'(a);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prog_active;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Read pipeline: one stage per cycle of latency. Stage 0 is loaded on the
    // accept edge; the output registers are loaded from the last stage.
    logic              r_stg_valid [RD_LAT];
    logic              r_stg_fault [RD_LAT];
    logic [MEM_AW-1:0] r_stg_idx   [RD_LAT];

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_fault;

    logic              w_accept;
    logic              w_req_fault;
    logic [MEM_AW-1:0] w_req_idx;
    logic              w_prog_we;
    logic [MEM_AW-1:0] w_prog_idx;
    logic              w_rsp_load;

    // -------------------------------------------------------------------------
    // Handshake, request decode and program-write qualification
    // -------------------------------------------------------------------------
    // Request handshake and address decode for both ports
    always_comb begin
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        w_req_fault = 1'b0;
        w_req_idx   = {MEM_AW{1'b0}};
        w_prog_we   = 1'b0;
        w_prog_idx  = {MEM_AW{1'b0}};

        if (!reset && (r_state == ST_IDLE) && !prog_en) begin
            req_ready = 1'b1;
        end else begin
            req_ready = 1'b0;
        end

        w_accept = req_valid && req_ready;

        if (addr_usable(req_addr)) begin
            w_req_fault = 1'b0;
            w_req_idx   = addr_index(req_addr);
        end else begin
            w_req_fault = 1'b1;
            w_req_idx   = {MEM_AW{1'b0}};
        end

        // Writes outside PROG, or to unusable addresses, are dropped here.
        if ((r_state == ST_PROG) && prog_wr && addr_usable(prog_addr)) begin
            w_prog_we  = 1'b1;
            w_prog_idx = addr_index(prog_addr);
        end else begin
            w_prog_we  = 1'b0;
            w_prog_idx = {MEM_AW{1'b0}};
        end
    end

    // -------------------------------------------------------------------------
    // In-flight counter
    // -------------------------------------------------------------------------
    // Counts accepted requests that have not yet reached the output registers;
    // saturates at both ends so no input sequence can wrap it.
    always_comb begin
        w_rsp_load = r_stg_valid[LAST];
        w_cnt_nxt  = r_cnt;
        case ({w_accept, w_rsp_load})
            2'b10: begin
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            2'b01: begin
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // In-flight counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= CNT_ZERO;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // Next-state logic. The counter reaches zero on the edge that loads the
    // last response, so in DRAIN a zero count means that response is being
    // presented now and PROG follows on the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (prog_en) begin
                    if (r_cnt != CNT_ZERO) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_PROG;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_PROG;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_PROG: begin
                if (!prog_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PROG;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered prog_active decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_prog_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prog_active <= (w_state_nxt == ST_PROG);
        end
    end

    // -------------------------------------------------------------------------
    // Memory array (not reset: contents survive reset)
    // -------------------------------------------------------------------------
    // Program-port write; the reset edge never writes
    always_ff @(posedge clk) begin
        if (!reset && w_prog_we) begin
            r_mem[w_prog_idx] <= prog_data;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline
    // -------------------------------------------------------------------------
    // Shift accepted requests towards the output; reset drops everything
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stg_valid[i] <= 1'b0;
                r_stg_fault[i] <= 1'b0;
                r_stg_idx[i]   <= {MEM_AW{1'b0}};
            end
        end else begin
            r_stg_valid[0] <= w_accept;
            r_stg_fault[0] <= w_accept && w_req_fault;
            r_stg_idx[0]   <= w_accept ? w_req_idx : {MEM_AW{1'b0}};
            for (int i = 1; i < RD_LAT; i++) begin
                r_stg_valid[i] <= r_stg_valid[i-1];
                r_stg_fault[i] <= r_stg_fault[i-1];
                r_stg_idx[i]   <= r_stg_idx[i-1];
            end
        end
    end

    // Output registers: memory is read only for a valid, non-faulting entry,
    // and data/fault are held at zero whenever rsp_valid is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {DATA_W{1'b0}};
            r_rsp_fault <= 1'b0;
        end else begin
            r_rsp_valid <= r_stg_valid[LAST];
            r_rsp_fault <= r_stg_valid[LAST] && r_stg_fault[LAST];
            if (r_stg_valid[LAST] && !r_stg_fault[LAST]) begin
                r_rsp_data <= r_mem[r_stg_idx[LAST]];
            end else begin
                r_rsp_data <= {DATA_W{1'b0}};
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_fault   = r_rsp_fault;
    assign prog_active = r_prog_active;

endmodule
